pc_seq_unit: RTL
================

Name: pc_seq_unit

Overview:
- Parametrised program-counter sequencer for the stack-based core.
- Accepts one control opcode per instruction slot and advances the PC.
- Branch targets and offsets come from the operand stack through a pop/valid handshake.
- Adds an internal return-address stack (RAS) for CALL/RET, relative jumps, inverted-zero branch, target range checking, and a selectable wrap/saturate mode at end of program.

Parameters:
- INST_CAP, 20, number of instruction slots; legal PC range 0..INST_CAP-1.
- DATA_LEN, 8, operand-stack data width.
- RAS_DEPTH, 4, return-address stack entries (>=1).
- WRAP, 0, 0 = PC saturates at INST_CAP-1 on sequential advance; 1 = PC wraps to 0.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- en  input  1  instruction-valid strobe, sampled only in IDLE
- op  input  4  opcode: 0 NOP, 1 JMP, 2 JZ, 3 JS, 4 JNZ, 5 CALL, 6 RET, 7 JREL, 8-15 HALT
- z_flag  input  1  zero flag
- s_flag  input  1  sign flag
- opd_pop  output  1  one-cycle pop request to the operand stack
- opd_valid  input  1  operand-stack data valid
- opd_data  input  DATA_LEN  target (absolute) or signed offset (JREL)
- pc  output  PC_W  program counter, PC_W = max(1, $clog2(INST_CAP))
- ready  output  1  high in IDLE; next en is accepted
- halted  output  1  sticky halt indication
- addr_err  output  1  one-cycle pulse on an out-of-range target
- ras_ovf  output  1  sticky: CALL with RAS full
- ras_unf  output  1  sticky: RET with RAS empty

Behaviour:
- Reset is asynchronous, active-low, on rstn; clock is clk.
- Reset values: state=IDLE, pc=0, opd_pop=0, ready=1, halted=0, addr_err=0, ras_ovf=0, ras_unf=0, RAS empty. Reset mid-operation aborts any in-flight pop/wait immediately.
- States: IDLE, POP, WAIT, HALT.
- IDLE, en=0: hold.
- IDLE, en=1, NOP: pc <= next_seq on the same edge; stay IDLE. Latency 1 cycle.
- IDLE, en=1, RET: if RAS non-empty, pc <= top and pop the RAS; else pc <= next_seq and set ras_unf. 1 cycle.
- IDLE, en=1, op>=8: go to HALT; pc holds.
- IDLE, en=1, ops 1-5 and 7: latch op, go to POP.
- POP: opd_pop=1 for exactly this cycle; go to WAIT. ready=0 in POP and WAIT.
- WAIT: hold until opd_valid=1. On that edge, resolve the latched op using z_flag/s_flag sampled on the same edge, then return to IDLE.
  - JMP: always taken.
  - JZ: taken if z_flag=1.
  - JNZ: taken if z_flag=0.
  - JS: taken if s_flag=1.
  - Not taken: pc <= next_seq.
  - CALL: if RAS full, set ras_ovf, no push, pc <= next_seq; else push next_seq and take the jump.
  - JREL: target = pc + sign-extended opd_data, computed at PC_W+DATA_LEN+1 bits.
  - Absolute target = zero-extended opd_data.
  - Taken with target outside 0..INST_CAP-1: pc unchanged, addr_err pulses 1 cycle, no RAS push.
- next_seq: pc+1 if pc<INST_CAP-1; otherwise INST_CAP-1 when WRAP=0, 0 when WRAP=1.
- en is ignored outside IDLE; an in-flight instruction always completes.
- HALT: halted=1, ready=0; all inputs ignored until reset.
- Minimum branch latency: 3 cycles (IDLE→POP→WAIT→IDLE with opd_valid in the first WAIT cycle).
- Sticky flags clear only on reset. The RAS is a LIFO with a pointer 0..RAS_DEPTH; no wrap.

Test Plan:
- Reset then en=1, op=0 for 25 cycles, INST_CAP=20, WRAP=0 -> pc counts 0..19 and holds at 19. Repeat with WRAP=1 -> pc goes 19→0.
- pc=3, op=2 (JZ), opd_valid one cycle after POP with opd_data=12: z=1 -> pc=12; z=0 -> pc=4. opd_pop high exactly 1 cycle; ready low for 2 cycles.
- pc=5, CALL opd_data=15 -> pc=15. Then RET -> pc=6. A second RET -> pc=7 and ras_unf=1.
- RAS_DEPTH=2: three nested CALLs -> the third sets ras_ovf=1 and pc=caller+1. Then two RETs unwind correctly.
- pc=10, JREL opd_data=8'hFA (-6) -> pc=4. JMP opd_data=25 -> pc unchanged, single-cycle addr_err pulse.
- Assert rstn=0 during WAIT -> pc=0, opd_pop=0, ready=1 immediately. Separately, op=8 -> halted=1 and subsequent en/op have no effect until reset.

Source files
------------

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer with operand-stack branch targets and a return-address stack.
// Latency: NOP/RET 1 cycle, branches 3+ cycles (waits in WAIT until opd_valid); ready low while busy or halted.
module pc_seq_unit #(
    parameter int INST_CAP  = 20,
    parameter int DATA_LEN  = 8,
    parameter int RAS_DEPTH = 4,
    parameter int WRAP      = 0,
    localparam int PC_W     = (INST_CAP > 1) ? $clog2(INST_CAP) : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic [3:0]          op,
    input  logic                z_flag,
    input  logic                s_flag,
    output logic                opd_pop,
    input  logic                opd_valid,
    input  logic [DATA_LEN-1:0] opd_data,
    output logic [PC_W-1:0]     pc,
    output logic                ready,
    output logic                halted,
    output logic                addr_err,
    output logic                ras_ovf,
    output logic                ras_unf
);
    localparam int RP_W = $clog2(RAS_DEPTH + 1);
    localparam int TW   = PC_W + DATA_LEN + 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(INST_CAP - 1);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_JMP  = 4'd1;
    localparam logic [3:0] OP_JZ   = 4'd2;
    localparam logic [3:0] OP_JS   = 4'd3;
    localparam logic [3:0] OP_JNZ  = 4'd4;
    localparam logic [3:0] OP_CALL = 4'd5;
    localparam logic [3:0] OP_RET  = 4'd6;
    localparam logic [3:0] OP_JREL = 4'd7;

    typedef enum logic [1:0] {IDLE, POP, WAIT, HALT} state_t;
    state_t state, state_nx;

    logic [3:0]      op_q;
    logic [RP_W-1:0] ras_ptr;
    logic [PC_W-1:0] ras_mem [2**RP_W];
    logic [PC_W-1:0] next_seq, ras_top, pc_nx;
    logic [TW-1:0]   tgt;
    logic            tgt_ok, taken, ras_full, ras_empty;
    logic            push, pop_ras, set_ovf, set_unf, aerr_nx;

    always_comb begin
        if (pc < PC_LAST)
            next_seq = pc + PC_W'(1);
        else
            next_seq = (WRAP != 0) ? '0 : PC_LAST;
    end

    // Relative targets are formed wide enough that a negative result shows up in the MSB.
    always_comb begin
        if (op_q == OP_JREL)
            tgt = TW'(pc) + {{(PC_W+1){opd_data[DATA_LEN-1]}}, opd_data};
        else
            tgt = TW'(opd_data);
    end

    assign tgt_ok    = !tgt[TW-1] && (tgt < TW'(INST_CAP));
    assign ras_top   = ras_mem[ras_ptr - RP_W'(1)];
    assign ras_full  = (ras_ptr == RP_W'(RAS_DEPTH));
    assign ras_empty = (ras_ptr == '0);

    always_comb begin
        case (op_q)
            OP_JZ:   taken = z_flag;
            OP_JNZ:  taken = !z_flag;
            OP_JS:   taken = s_flag;
            default: taken = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        push     = 1'b0;
        pop_ras  = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        aerr_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    if (op[3]) begin
                        state_nx = HALT;
                    end else if (op == OP_NOP) begin
                        pc_nx = next_seq;
                    end else if (op == OP_RET) begin
                        if (!ras_empty) begin
                            pc_nx   = ras_top;
                            pop_ras = 1'b1;
                        end else begin
                            pc_nx   = next_seq;
                            set_unf = 1'b1;
                        end
                    end else begin
                        state_nx = POP;
                    end
                end
            end
            POP:  state_nx = WAIT;
            WAIT: begin
                if (opd_valid) begin
                    state_nx = IDLE;
                    if (!taken) begin
                        pc_nx = next_seq;
                    end else if (op_q == OP_CALL && ras_full) begin
                        set_ovf = 1'b1;
                        pc_nx   = next_seq;
                    end else if (!tgt_ok) begin
                        aerr_nx = 1'b1;
                    end else begin
                        pc_nx = tgt[PC_W-1:0];
                        push  = (op_q == OP_CALL);
                    end
                end
            end
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    assign opd_pop = (state == POP);
    assign ready   = (state == IDLE);
    assign halted  = (state == HALT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc       <= '0;
            op_q     <= '0;
            ras_ptr  <= '0;
            addr_err <= 1'b0;
            ras_ovf  <= 1'b0;
            ras_unf  <= 1'b0;
        end else begin
            pc       <= pc_nx;
            addr_err <= aerr_nx;
            if (state == IDLE && en) op_q <= op;
            if (set_ovf) ras_ovf <= 1'b1;
            if (set_unf) ras_unf <= 1'b1;
            if (push)
                ras_ptr <= ras_ptr + RP_W'(1);
            else if (pop_ras)
                ras_ptr <= ras_ptr - RP_W'(1);
        end
    end

    // Return address is the caller's sequential successor, written at the current top.
    always_ff @(posedge clk) begin
        if (push) ras_mem[ras_ptr] <= next_seq;
    end
endmodule
